// File: rtl/note_sequencer.sv
// note_sequencer: programmable 16-step pattern sequencer driving scale_rom and voice.
// Emits note index, gate and a one-cycle step strobe at a fixed step period.
module note_sequencer #(
    parameter int unsigned STEP_CYCLES = 131072,
    parameter int unsigned GATE_CYCLES = 65536
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [3:0] last_step,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [4:0] wr_data,
    output logic [3:0] note_out,
    output logic       gate_out,
    output logic [3:0] step_idx,
    output logic       step_strobe
);

    localparam int CW = $clog2(STEP_CYCLES);
    localparam logic [CW-1:0] GATE_LAST = CW'(GATE_CYCLES - 1);
    localparam logic [CW-1:0] STEP_LAST = CW'(STEP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        GATE_ON,
        GATE_OFF
    } state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [3:0]    step_d, note_d;
    logic          gate_d, strobe_d;
    logic          load;
    logic [3:0]    load_idx;
    logic [4:0]    pattern [16];

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            step_idx    <= '0;
            note_out    <= '0;
            gate_out    <= 1'b0;
            step_strobe <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            step_idx    <= step_d;
            note_out    <= note_d;
            gate_out    <= gate_d;
            step_strobe <= strobe_d;
        end
    end

    // Reads in the load path see the pre-write value on a same-edge write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                pattern[i] <= {1'b0, 4'(i)};
            end
        end else if (wr_en) begin
            pattern[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        state_d  = state;
        cnt_d    = cnt + CW'(1);
        step_d   = step_idx;
        note_d   = note_out;
        gate_d   = gate_out;
        strobe_d = 1'b0;
        load     = 1'b0;
        load_idx = step_idx;
        unique case (state)
            IDLE: begin
                cnt_d = '0;
                if (run) begin
                    load = 1'b1;
                end
            end
            GATE_ON: begin
                if (!run) begin
                    state_d = IDLE;
                    gate_d  = 1'b0;
                    cnt_d   = '0;
                end else if (cnt == GATE_LAST) begin
                    state_d = GATE_OFF;
                    gate_d  = 1'b0;
                end
            end
            GATE_OFF: begin
                if (!run) begin
                    state_d = IDLE;
                    gate_d  = 1'b0;
                    cnt_d   = '0;
                end else if (cnt == STEP_LAST) begin
                    load     = 1'b1;
                    load_idx = (step_idx >= last_step) ? 4'd0
                                                       : step_idx + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                gate_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
        if (load) begin
            state_d  = GATE_ON;
            cnt_d    = '0;
            step_d   = load_idx;
            note_d   = pattern[load_idx][3:0];
            gate_d   = ~pattern[load_idx][4];
            strobe_d = 1'b1;
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: directed scenarios plus randomized run against a
// phase-based behavioural model of the step sequencer.
module tb_note_sequencer;

    localparam int STEP = 16;
    localparam int GATE = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       run = 1'b0;
    logic [3:0] last_step = '0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [4:0] wr_data = '0;
    logic [3:0] note_out;
    logic       gate_out;
    logic [3:0] step_idx;
    logic       step_strobe;

    int errors = 0;
    int checks = 0;

    note_sequencer #(
        .STEP_CYCLES(STEP),
        .GATE_CYCLES(GATE)
    ) dut (
        .clk(clk),
        .reset(reset),
        .run(run),
        .last_step(last_step),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .note_out(note_out),
        .gate_out(gate_out),
        .step_idx(step_idx),
        .step_strobe(step_strobe)
    );

    always #5 clk = ~clk;

    // Model: a step is "playing" with a phase = clocks since it was loaded.
    logic [4:0] pat [16];
    bit         m_act;
    int         m_phase;
    int         m_step;
    int         m_note;
    bit         m_rest;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    task automatic m_load(int n);
        m_act   = 1'b1;
        m_phase = 0;
        m_step  = n;
        m_note  = int'(pat[n][3:0]);
        m_rest  = pat[n][4];
    endtask

    task automatic model_update();
        if (reset) begin
            m_act   = 1'b0;
            m_phase = 0;
            m_step  = 0;
            m_note  = 0;
            m_rest  = 1'b0;
            for (int i = 0; i < 16; i++) pat[i] = {1'b0, 4'(i)};
        end else begin
            if (!m_act) begin
                if (run) m_load(m_step);
            end else if (!run) begin
                m_act = 1'b0;
            end else if (m_phase == STEP - 1) begin
                m_load((m_step >= int'(last_step)) ? 0 : m_step + 1);
            end else begin
                m_phase++;
            end
            if (wr_en) pat[wr_addr] = wr_data;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        chk("model_note", int'(note_out), m_note);
        chk("model_step", int'(step_idx), m_step);
        chk("model_gate", int'(gate_out),
            int'(m_act && !m_rest && m_phase < GATE));
        chk("model_strobe", int'(step_strobe),
            int'(m_act && m_phase == 0));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        run   = 1'b0;
        wr_en = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    int nstb;
    int ghi;

    initial begin
        // Scenario 1: default pattern, loop of 4 steps.
        do_reset();
        chk("rst_note", int'(note_out), 0);
        chk("rst_gate", int'(gate_out), 0);
        chk("rst_step", int'(step_idx), 0);
        chk("rst_strobe", int'(step_strobe), 0);
        last_step = 4'd3;
        run = 1'b1;
        nstb = 0;
        for (int k = 1; k <= 80; k++) begin
            tick();
            if (step_strobe) begin
                if (nstb < 5) begin
                    chk("s1_strobe_cyc", k, 1 + 16 * nstb);
                    chk("s1_note", int'(note_out), nstb % 4);
                end
                nstb++;
            end
            if (k == 8) chk("s1_gate_last_high", int'(gate_out), 1);
            if (k == 9) chk("s1_gate_low", int'(gate_out), 0);
        end
        chk("s1_strobe_count", nstb, 5);

        // Scenario 2: rest on step 2.
        do_reset();
        wr_en = 1'b1;
        wr_addr = 4'd2;
        wr_data = 5'b1_0101;
        tick();
        wr_en = 1'b0;
        last_step = 4'd3;
        run = 1'b1;
        ghi = 0;
        for (int k = 1; k <= 48; k++) begin
            tick();
            if (k == 33) begin
                chk("s2_step", int'(step_idx), 2);
                chk("s2_note", int'(note_out), 5);
            end
            if (k >= 33 && gate_out) ghi++;
        end
        chk("s2_rest_gate_cycles", ghi, 0);

        // Scenario 3: pause during gate, resume replays the step.
        do_reset();
        last_step = 4'd3;
        for (int k = 1; k <= 47; k++) begin
            run = !(k >= 22 && k <= 30);
            tick();
            if (k == 21) chk("s3_gate_before", int'(gate_out), 1);
            if (k == 22) begin
                chk("s3_gate_paused", int'(gate_out), 0);
                chk("s3_step_held", int'(step_idx), 1);
            end
            if (k == 31) begin
                chk("s3_restrobe", int'(step_strobe), 1);
                chk("s3_restep", int'(step_idx), 1);
            end
            if (k == 38) chk("s3_gate_end", int'(gate_out), 1);
            if (k == 39) chk("s3_gate_off", int'(gate_out), 0);
            if (k == 47) begin
                chk("s3_next_strobe", int'(step_strobe), 1);
                chk("s3_next_step", int'(step_idx), 2);
            end
        end

        // Scenario 4: shrink loop below current step.
        do_reset();
        last_step = 4'd15;
        run = 1'b1;
        for (int k = 1; k <= 65; k++) begin
            if (k == 50) last_step = 4'd1;
            tick();
            if (k == 49) chk("s4_step3", int'(step_idx), 3);
            if (k == 65) begin
                chk("s4_wrap_strobe", int'(step_strobe), 1);
                chk("s4_wrap_step", int'(step_idx), 0);
            end
        end

        // Scenario 5: write on the same edge that loads the entry.
        do_reset();
        last_step = 4'd3;
        run = 1'b1;
        for (int k = 1; k <= 81; k++) begin
            wr_en = (k == 17);
            wr_addr = 4'd1;
            wr_data = 5'h0A;
            tick();
            if (k == 17) chk("s5_old_note", int'(note_out), 1);
            if (k == 81) begin
                chk("s5_step", int'(step_idx), 1);
                chk("s5_new_note", int'(note_out), 10);
            end
        end
        wr_en = 1'b0;

        // Scenario 6: reset mid gate restores default pattern.
        do_reset();
        wr_en = 1'b1;
        wr_addr = 4'd0;
        wr_data = 5'h07;
        tick();
        wr_en = 1'b0;
        last_step = 4'd3;
        run = 1'b1;
        for (int k = 1; k <= 4; k++) tick();
        chk("s6_note_written", int'(note_out), 7);
        chk("s6_gate_on", int'(gate_out), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("s6_rst_note", int'(note_out), 0);
        chk("s6_rst_gate", int'(gate_out), 0);
        chk("s6_rst_strobe", int'(step_strobe), 0);
        tick();
        chk("s6_restart_strobe", int'(step_strobe), 1);
        chk("s6_restart_step", int'(step_idx), 0);
        chk("s6_restart_note", int'(note_out), 0);

        // Randomized traffic against the model.
        do_reset();
        last_step = 4'($urandom_range(0, 15));
        for (int k = 0; k < 3000; k++) begin
            run = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 49) == 0)
                last_step = 4'($urandom_range(0, 15));
            wr_en = ($urandom_range(0, 9) == 0);
            wr_addr = 4'($urandom_range(0, 15));
            wr_data = 5'($urandom_range(0, 31));
            reset = ($urandom_range(0, 499) == 0);
            tick();
        end
        reset = 1'b0;
        wr_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
